// File: rtl/sim_lockstep_ctrl.sv
// Lockstep sequencer between the core retire stream and the ISS co-sim interface.
// Buffers retired PC/insn pairs, issues them one at a time, compares ISS responses.
`timescale 1ns/1ps
module sim_lockstep_ctrl #(
  parameter int DEPTH    = 8,
  parameter int MAX_MISS = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ret_valid,
  output logic              ret_ready,
  input  logic [63:0]       ret_pc,
  input  logic [31:0]       ret_insn,
  output logic [63:0]       sim_pc_in,
  input  logic [63:0]       sim_pc_out,
  input  logic [31:0]       sim_insn,
  input  logic              sim_miss,
  output logic              chk_done,
  output logic              chk_pass,
  output logic [31:0]       checked_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              halted,
  output logic [63:0]       err_pc,
  output logic [31:0]       err_insn_exp,
  output logic [31:0]       err_insn_got
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, HALT} state_t;
  state_t state, state_nxt;

  logic [63:0]      fifo_pc   [DEPTH];
  logic [31:0]      fifo_insn [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, count;
  logic             empty, full, push, pop, fail;
  logic [63:0]      head_pc;
  logic [31:0]      head_insn;
  logic [CNT_W-1:0] mis_upd;

  assign count     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign halted    = (state == HALT);
  // No pass-through: a pop in the same cycle does not open a full FIFO.
  assign ret_ready = !full && !halted;
  assign push      = ret_valid && ret_ready;
  assign pop       = (state == RESP);
  assign head_pc   = fifo_pc[rd_ptr[AW-1:0]];
  assign head_insn = fifo_insn[rd_ptr[AW-1:0]];

  assign fail     = sim_miss || (sim_insn != head_insn);
  assign mis_upd  = (fail && (mismatch_cnt != '1)) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;
  assign chk_done = (state == RESP);
  assign chk_pass = (state == RESP) && !fail;
  // Inverted PC can never equal the ISS expected PC, so the ISS holds still.
  assign sim_pc_in = (state == ISSUE) ? head_pc : ~sim_pc_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en && !empty) state_nxt = ISSUE;
      ISSUE: state_nxt = RESP;
      RESP: begin
        if (mis_upd >= CNT_W'(MAX_MISS))                    state_nxt = HALT;
        else if (en && ((count > (AW+1)'(1)) || push))      state_nxt = ISSUE;
        else                                                state_nxt = IDLE;
      end
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      checked_cnt  <= '0;
      mismatch_cnt <= '0;
      err_pc       <= '0;
      err_insn_exp <= '0;
      err_insn_got <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr       <= rd_ptr + (AW+1)'(1);
        mismatch_cnt <= mis_upd;
        if (checked_cnt != '1) checked_cnt <= checked_cnt + 32'd1;
        // Counter saturates rather than wraps, so zero means no earlier failure.
        if (fail && (mismatch_cnt == '0)) begin
          err_pc       <= head_pc;
          err_insn_exp <= sim_insn;
          err_insn_got <= head_insn;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr[AW-1:0]]   <= ret_pc;
      fifo_insn[wr_ptr[AW-1:0]] <= ret_insn;
    end
  end
endmodule

// File: tb/tb_sim_lockstep_ctrl.sv
// Directed bench: two DUTs (MAX_MISS=1 and 2) each driving a small ISS stand-in.
`timescale 1ns/1ps
module tb_sim_lockstep_ctrl;
  logic        clk = 1'b0;
  logic        rst, en, ret_valid;
  logic [63:0] ret_pc;
  logic [31:0] ret_insn;

  logic        rdy [2];
  logic [63:0] pc_in [2];
  logic [63:0] pc_exp [2];
  logic [31:0] s_insn [2];
  logic        s_miss [2];
  logic        done [2];
  logic        pass [2];
  logic [31:0] chk_cnt [2];
  logic [15:0] mis_cnt [2];
  logic        hlt [2];
  logic [63:0] e_pc [2];
  logic [31:0] e_exp [2];
  logic [31:0] e_got [2];

  logic        iss_load, force_miss;
  logic [63:0] iss_load_pc;
  logic [31:0] tab [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ISS stand-in: advances and answers only when pc_in equals its expected PC.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (iss_load) pc_exp[i] <= iss_load_pc;
      else if (pc_in[i] == pc_exp[i]) begin
        pc_exp[i] <= pc_exp[i] + 64'd4;
        s_insn[i] <= tab[pc_exp[i][5:2]];
        s_miss[i] <= force_miss;
      end else s_miss[i] <= 1'b1;
    end
  end

  sim_lockstep_ctrl #(.DEPTH(8), .MAX_MISS(1), .CNT_W(16)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .ret_valid(ret_valid), .ret_ready(rdy[0]),
    .ret_pc(ret_pc), .ret_insn(ret_insn), .sim_pc_in(pc_in[0]), .sim_pc_out(pc_exp[0]),
    .sim_insn(s_insn[0]), .sim_miss(s_miss[0]), .chk_done(done[0]), .chk_pass(pass[0]),
    .checked_cnt(chk_cnt[0]), .mismatch_cnt(mis_cnt[0]), .halted(hlt[0]),
    .err_pc(e_pc[0]), .err_insn_exp(e_exp[0]), .err_insn_got(e_got[0]));

  sim_lockstep_ctrl #(.DEPTH(8), .MAX_MISS(2), .CNT_W(16)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .ret_valid(ret_valid), .ret_ready(rdy[1]),
    .ret_pc(ret_pc), .ret_insn(ret_insn), .sim_pc_in(pc_in[1]), .sim_pc_out(pc_exp[1]),
    .sim_insn(s_insn[1]), .sim_miss(s_miss[1]), .chk_done(done[1]), .chk_pass(pass[1]),
    .checked_cnt(chk_cnt[1]), .mismatch_cnt(mis_cnt[1]), .halted(hlt[1]),
    .err_pc(e_pc[1]), .err_insn_exp(e_exp[1]), .err_insn_got(e_got[1]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; en = 1'b0; ret_valid = 1'b0; force_miss = 1'b0;
    for (int i = 0; i < 16; i++) tab[i] = 32'h13;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic load_iss(input logic [63:0] pc);
    iss_load = 1'b1; iss_load_pc = pc;
    tick;
    iss_load = 1'b0;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] insn);
    ret_valid = 1'b1; ret_pc = pc; ret_insn = insn;
    tick;
    ret_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; ret_valid = 1'b0;
    tick; tick;
    vectors++; if (rdy[1] !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", rdy[1]); end
    vectors++; if (done[1] !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done[1]); end
    vectors++; if (chk_cnt[1] !== 32'd0 || mis_cnt[1] !== 16'd0) begin miscompares++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0", chk_cnt[1], mis_cnt[1]); end
    vectors++; if (hlt[1] !== 1'b0 || e_pc[1] !== 64'd0 || e_exp[1] !== 32'd0 || e_got[1] !== 32'd0) begin
      miscompares++; $display("FAIL reset_err got halt=%b pc=%h want 0", hlt[1], e_pc[1]); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int n;
    apply_reset;
    load_iss(64'h1000);
    en = 1'b1;
    push(64'h1000, 32'h13);
    n = 0;
    while (!done[1] && n < 10) begin tick; n++; end
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL single_latency got %0d want 2", n); end
    vectors++; if (pass[1] !== 1'b1) begin miscompares++; $display("FAIL single_pass got %b want 1", pass[1]); end
    tick;
    vectors++; if (chk_cnt[1] !== 32'd1 || mis_cnt[1] !== 16'd0) begin miscompares++;
      $display("FAIL single_cnt got %0d/%0d want 1/0", chk_cnt[1], mis_cnt[1]); end
  endtask

  task automatic test_back_to_back;
    logic [13:0] d, inv, want_d;
    int pc_bad;
    apply_reset;
    load_iss(64'h1100);
    en = 1'b1;
    pc_bad = 0;
    for (int c = 0; c < 14; c++) begin
      ret_valid = (c < 4); ret_pc = 64'h1100 + 64'(4 * c); ret_insn = 32'h13;
      d[c]   = done[1];
      inv[c] = (pc_in[1] == ~pc_exp[1]);
      if (c == 2 || c == 4 || c == 6 || c == 8)
        if (pc_in[1] !== 64'h1100 + 64'(2 * (c - 2))) pc_bad++;
      tick;
    end
    ret_valid = 1'b0;
    want_d = 14'b00_0010_1010_1000;
    vectors++; if (d !== want_d) begin miscompares++; $display("FAIL b2b_done_pattern got %b want %b", d, want_d); end
    vectors++; if (inv !== 14'b11_1110_1010_1011) begin miscompares++;
      $display("FAIL b2b_inverted_pc got %b want %b", inv, 14'b11_1110_1010_1011); end
    vectors++; if (pc_bad !== 0) begin miscompares++; $display("FAIL b2b_issue_pc got %0d bad want 0", pc_bad); end
    vectors++; if (chk_cnt[1] !== 32'd4 || mis_cnt[1] !== 16'd0) begin miscompares++;
      $display("FAIL b2b_cnt got %0d/%0d want 4/0", chk_cnt[1], mis_cnt[1]); end
  endtask

  task automatic test_halt_miss;
    int n, extra;
    apply_reset;
    load_iss(64'h2000);
    force_miss = 1'b1;
    en = 1'b1;
    push(64'h2000, 32'h13);
    n = 0;
    while (!done[0] && n < 10) begin tick; n++; end
    vectors++; if (done[0] !== 1'b1 || pass[0] !== 1'b0) begin miscompares++;
      $display("FAIL miss_pass got done=%b pass=%b want 1/0", done[0], pass[0]); end
    tick;
    force_miss = 1'b0;
    vectors++; if (hlt[0] !== 1'b1 || rdy[0] !== 1'b0) begin miscompares++;
      $display("FAIL miss_halt got halt=%b ready=%b want 1/0", hlt[0], rdy[0]); end
    vectors++; if (e_pc[0] !== 64'h2000 || mis_cnt[0] !== 16'd1) begin miscompares++;
      $display("FAIL miss_err got pc=%h cnt=%0d want 2000/1", e_pc[0], mis_cnt[0]); end
    ret_valid = 1'b1; ret_pc = 64'h2004; ret_insn = 32'h13;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (rdy[0] || done[0]) extra++;
      tick;
    end
    ret_valid = 1'b0;
    vectors++; if (extra !== 0 || chk_cnt[0] !== 32'd1) begin miscompares++;
      $display("FAIL miss_blocked got %0d events cnt=%0d want 0/1", extra, chk_cnt[0]); end
  endtask

  task automatic test_max_miss;
    int n;
    logic [2:0] want_pass;
    apply_reset;
    load_iss(64'h3000);
    tab[0] = 32'h33; tab[1] = 32'h13; tab[2] = 32'h33;
    want_pass = 3'b010;
    en = 1'b1;
    push(64'h3000, 32'h13);
    push(64'h3004, 32'h13);
    push(64'h3008, 32'h13);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!done[1] && n < 10) begin tick; n++; end
      vectors++; if (done[1] !== 1'b1 || pass[1] !== want_pass[k]) begin miscompares++;
        $display("FAIL maxmiss_pass%0d got done=%b pass=%b want 1/%b", k, done[1], pass[1], want_pass[k]); end
      tick;
      if (k < 2) begin
        vectors++; if (hlt[1] !== 1'b0) begin miscompares++; $display("FAIL maxmiss_early_halt%0d got 1 want 0", k); end
      end
    end
    vectors++; if (hlt[1] !== 1'b1 || mis_cnt[1] !== 16'd2) begin miscompares++;
      $display("FAIL maxmiss_halt got halt=%b cnt=%0d want 1/2", hlt[1], mis_cnt[1]); end
    vectors++; if (e_pc[1] !== 64'h3000 || e_exp[1] !== 32'h33 || e_got[1] !== 32'h13) begin miscompares++;
      $display("FAIL maxmiss_err got %h/%h/%h want 3000/33/13", e_pc[1], e_exp[1], e_got[1]); end
  endtask

  task automatic test_fill_drain;
    int acc, dn, ps, n;
    apply_reset;
    load_iss(64'h4000);
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      ret_valid = 1'b1; ret_pc = 64'h4000 + 64'(4 * acc); ret_insn = 32'h13;
      if (rdy[1]) acc++;
      tick;
    end
    ret_valid = 1'b0;
    vectors++; if (acc !== 8 || rdy[1] !== 1'b0) begin miscompares++;
      $display("FAIL fill_accept got %0d ready=%b want 8/0", acc, rdy[1]); end
    en = 1'b1;
    tick; tick;
    vectors++; if (done[1] !== 1'b1 || rdy[1] !== 1'b0) begin miscompares++;
      $display("FAIL fill_nopass got done=%b ready=%b want 1/0", done[1], rdy[1]); end
    dn = 1; ps = pass[1];
    tick;
    vectors++; if (rdy[1] !== 1'b1) begin miscompares++; $display("FAIL fill_ready_back got 0 want 1"); end
    n = 0;
    while (dn < 8 && n < 40) begin
      if (done[1]) begin dn++; ps += pass[1]; end
      tick; n++;
    end
    vectors++; if (dn !== 8 || ps !== 8) begin miscompares++;
      $display("FAIL drain_order got %0d done %0d pass want 8/8", dn, ps); end
  endtask

  task automatic test_reset_resp;
    int extra;
    apply_reset;
    load_iss(64'h5000);
    push(64'h5000, 32'h13);
    push(64'h5004, 32'h13);
    push(64'h5008, 32'h13);
    en = 1'b1;
    tick; tick;
    vectors++; if (done[1] !== 1'b1) begin miscompares++; $display("FAIL rstresp_in_resp got 0 want 1"); end
    rst = 1'b1;
    #1;
    vectors++; if (done[1] !== 1'b0 || rdy[1] !== 1'b1 || chk_cnt[1] !== 32'd0 || hlt[1] !== 1'b0) begin
      miscompares++; $display("FAIL rstresp_clear got done=%b ready=%b cnt=%0d want 0/1/0", done[1], rdy[1], chk_cnt[1]); end
    tick;
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (done[1]) extra++;
      tick;
    end
    vectors++; if (extra !== 0 || chk_cnt[1] !== 32'd0) begin miscompares++;
      $display("FAIL rstresp_empty got %0d checks cnt=%0d want 0/0", extra, chk_cnt[1]); end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ret_valid = 1'b0; ret_pc = '0; ret_insn = '0;
    iss_load = 1'b0; iss_load_pc = '0; force_miss = 1'b0;
    for (int i = 0; i < 16; i++) tab[i] = 32'h13;
    test_reset;
    test_single;
    test_back_to_back;
    test_halt_miss;
    test_max_miss;
    test_fill_drain;
    test_reset_resp;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
